// File: rtl/kbd_ascii_fifo.sv
// -----------------------------------------------------------------------------
// kbd_ascii_fifo
//
// Turns a stream of PS/2 set-2 scancode bytes into ASCII characters and
// queues them in a small show-ahead FIFO. A prefix decoder tracks 0xF0
// (break) and 0xE0 (extended) prefixes, the shift keys and caps-lock are
// tracked for case and digit-symbol selection, and every printable make,
// including typematic repeats, produces one character.
//
// Parameters
//   DEPTH     FIFO depth in characters (power of 2, >= 2)
//   SHIFT_EN  1: honour shift / caps-lock; 0: lowercase letters, plain digits
//
// Ports
//   clk         in   clock; all state changes on its rising edge
//   clrn        in   synchronous active-low reset
//   code_in     in   [7:0] scancode byte from the PS/2 receiver
//   code_valid  in   one-cycle strobe qualifying code_in
//   rd_en       in   pop the FIFO head (ignored when empty)
//   asc_out     out  [7:0] ASCII character at the FIFO head, 0x00 when empty
//   asc_ready   out  FIFO holds at least one character
//   overflow    out  sticky: a character was dropped because the FIFO was full
//   shift_st    out  either shift key currently held
//   caps_st     out  caps-lock state
//   make_cnt    out  [7:0] count of printable make events, wraps at 255
// -----------------------------------------------------------------------------
module kbd_ascii_fifo #(
    parameter int DEPTH    = 8,
    parameter bit SHIFT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] code_in,
    input  logic       code_valid,
    input  logic       rd_en,
    output logic [7:0] asc_out,
    output logic       asc_ready,
    output logic       overflow,
    output logic       shift_st,
    output logic       caps_st,
    output logic [7:0] make_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } dec_state_t;

    // -------------------------------------------------------------------------
    // Scancode to ASCII lookup. Returns {printable, ascii}. Letters flip to
    // uppercase when shift XOR caps; digits take their US shifted symbol when
    // shift alone is held.
    // -------------------------------------------------------------------------
    function automatic logic [8:0] map_code(input logic [7:0] code,
                                            input logic       shf,
                                            input logic       cap);
        logic [7:0] lower;
        logic [7:0] digit;
        logic [7:0] symbol;
        logic       is_letter;
        logic       is_digit;
        logic [8:0] result;

        lower     = 8'h00;
        digit     = 8'h00;
        symbol    = 8'h00;
        is_letter = 1'b0;
        is_digit  = 1'b0;
        result    = 9'h000;

        case (code)
            8'h1C: begin is_letter = 1'b1; lower = "a"; end
            8'h32: begin is_letter = 1'b1; lower = "b"; end
            8'h21: begin is_letter = 1'b1; lower = "c"; end
            8'h23: begin is_letter = 1'b1; lower = "d"; end
            8'h24: begin is_letter = 1'b1; lower = "e"; end
            8'h2B: begin is_letter = 1'b1; lower = "f"; end
            8'h34: begin is_letter = 1'b1; lower = "g"; end
            8'h33: begin is_letter = 1'b1; lower = "h"; end
            8'h43: begin is_letter = 1'b1; lower = "i"; end
            8'h3B: begin is_letter = 1'b1; lower = "j"; end
            8'h42: begin is_letter = 1'b1; lower = "k"; end
            8'h4B: begin is_letter = 1'b1; lower = "l"; end
            8'h3A: begin is_letter = 1'b1; lower = "m"; end
            8'h31: begin is_letter = 1'b1; lower = "n"; end
            8'h44: begin is_letter = 1'b1; lower = "o"; end
            8'h4D: begin is_letter = 1'b1; lower = "p"; end
            8'h15: begin is_letter = 1'b1; lower = "q"; end
            8'h2D: begin is_letter = 1'b1; lower = "r"; end
            8'h1B: begin is_letter = 1'b1; lower = "s"; end
            8'h2C: begin is_letter = 1'b1; lower = "t"; end
            8'h3C: begin is_letter = 1'b1; lower = "u"; end
            8'h2A: begin is_letter = 1'b1; lower = "v"; end
            8'h1D: begin is_letter = 1'b1; lower = "w"; end
            8'h22: begin is_letter = 1'b1; lower = "x"; end
            8'h35: begin is_letter = 1'b1; lower = "y"; end
            8'h1A: begin is_letter = 1'b1; lower = "z"; end
            8'h45: begin is_digit = 1'b1; digit = "0"; symbol = ")"; end
            8'h16: begin is_digit = 1'b1; digit = "1"; symbol = "!"; end
            8'h1E: begin is_digit = 1'b1; digit = "2"; symbol = "@"; end
            8'h26: begin is_digit = 1'b1; digit = "3"; symbol = "#"; end
            8'h25: begin is_digit = 1'b1; digit = "4"; symbol = "$"; end
            8'h2E: begin is_digit = 1'b1; digit = "5"; symbol = "%"; end
            8'h36: begin is_digit = 1'b1; digit = "6"; symbol = "^"; end
            8'h3D: begin is_digit = 1'b1; digit = "7"; symbol = "&"; end
            8'h3E: begin is_digit = 1'b1; digit = "8"; symbol = "*"; end
            8'h46: begin is_digit = 1'b1; digit = "9"; symbol = "("; end
            8'h29: result = {1'b1, 8'h20};
            8'h5A: result = {1'b1, 8'h0D};
            default: result = 9'h000;
        endcase

        if (is_letter) begin
            result = {1'b1, (shf ^ cap) ? (lower - 8'h20) : lower};
        end
        if (is_digit) begin
            result = {1'b1, shf ? symbol : digit};
        end
        return result;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    dec_state_t    state;
    logic          lshift;
    logic          rshift;
    logic          caps_held;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    // -------------------------------------------------------------------------
    // Decode of the current byte
    // -------------------------------------------------------------------------
    logic       make_ev;
    logic       break_ev;
    logic [8:0] mapped;
    logic       push;
    logic       pop;
    logic       full;
    logic       push_ok;

    // NOTE: every signal driven here gets a default first, so no path through
    // the block can leave it unassigned and infer a latch.
    always_comb begin
        make_ev  = 1'b0;
        break_ev = 1'b0;
        if (code_valid) begin
            make_ev  = (state == ST_IDLE) && (code_in != SC_BREAK) && (code_in != SC_EXT);
            break_ev = (state == ST_BRK);
        end

        // Case selection uses the registered shift/caps state, i.e. the value
        // before this byte is applied.
        mapped  = map_code(code_in, SHIFT_EN && shift_st, SHIFT_EN && caps_st);
        push    = make_ev && mapped[8];

        full    = (count == FULL_CNT);
        pop     = rd_en && asc_ready;
        // A pop on the same edge frees the slot, so a full FIFO still accepts.
        push_ok = push && (!full || pop);
    end

    assign shift_st  = lshift | rshift;
    assign asc_ready = (count != '0);
    assign asc_out   = asc_ready ? mem[rd_ptr] : 8'h00;

    // -------------------------------------------------------------------------
    // Character storage
    // -------------------------------------------------------------------------
    // NOTE: the storage array has no reset; entries are only observable once
    // written, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (clrn && push_ok) begin
            mem[wr_ptr] <= mapped[7:0];
        end
    end

    // -------------------------------------------------------------------------
    // Decoder FSM, modifier tracking, FIFO pointers and status
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state     <= ST_IDLE;
            lshift    <= 1'b0;
            rshift    <= 1'b0;
            caps_st   <= 1'b0;
            caps_held <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            make_cnt  <= 8'h00;
        end else begin
            // Prefix tracking
            if (code_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (code_in == SC_BREAK)    state <= ST_BRK;
                        else if (code_in == SC_EXT) state <= ST_EXT;
                        else                        state <= ST_IDLE;
                    end
                    ST_BRK:     state <= ST_IDLE;
                    ST_EXT:     state <= (code_in == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
                    ST_EXT_BRK: state <= ST_IDLE;
                    default:    state <= ST_IDLE;
                endcase
            end

            // Modifier keys; with SHIFT_EN clear they never leave reset.
            if (SHIFT_EN && make_ev) begin
                if (code_in == SC_LSHIFT) lshift <= 1'b1;
                if (code_in == SC_RSHIFT) rshift <= 1'b1;
                if (code_in == SC_CAPS) begin
                    // Only the first make of a hold toggles; typematic
                    // repeats arrive with caps_held already set.
                    if (!caps_held) caps_st <= ~caps_st;
                    caps_held <= 1'b1;
                end
            end
            if (SHIFT_EN && break_ev) begin
                if (code_in == SC_LSHIFT) lshift    <= 1'b0;
                if (code_in == SC_RSHIFT) rshift    <= 1'b0;
                if (code_in == SC_CAPS)   caps_held <= 1'b0;
            end

            // Every printable make counts, even when its character is dropped.
            if (push) begin
                make_cnt <= make_cnt + 8'd1;
            end
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end

            // FIFO pointers wrap naturally because DEPTH is a power of two.
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_kbd_ascii_fifo.sv
// -----------------------------------------------------------------------------
// tb_kbd_ascii_fifo
//
// Directed stimulus for kbd_ascii_fifo. A behavioural model (character queue,
// prefix byte list, modifier flags) predicts every output; a compare process
// checks the DUT against it on each falling edge, and the stimulus thread adds
// hand-computed literal expectations at the key points of each scenario.
// -----------------------------------------------------------------------------
module tb_kbd_ascii_fifo;

    localparam int DEPTH = 8;

    logic       clk;
    logic       clrn;
    logic [7:0] code_in;
    logic       code_valid;
    logic       rd_en;
    logic [7:0] asc_out;
    logic       asc_ready;
    logic       overflow;
    logic       shift_st;
    logic       caps_st;
    logic [7:0] make_cnt;

    kbd_ascii_fifo #(.DEPTH(DEPTH), .SHIFT_EN(1'b1)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .code_in    (code_in),
        .code_valid (code_valid),
        .rd_en      (rd_en),
        .asc_out    (asc_out),
        .asc_ready  (asc_ready),
        .overflow   (overflow),
        .shift_st   (shift_st),
        .caps_st    (caps_st),
        .make_cnt   (make_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model
    // -------------------------------------------------------------------------
    logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                      8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                      8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                      8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_codes [10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                      8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    string      digit_syms        = ")!@#$%^&*(";

    logic [7:0] m_q[$];       // characters queued, head first
    logic [7:0] m_prefix[$];  // prefix bytes seen since the last complete event
    bit         m_lsh, m_rsh, m_caps, m_caps_down, m_ovf;
    logic [7:0] m_cnt;
    bit         m_live = 1'b0;

    // Returns 1 and the character when the make code is printable.
    function automatic bit model_char(input logic [7:0] code, input bit shf, input bit cap,
                                      output logic [7:0] ch);
        ch = 8'h00;
        for (int i = 0; i < 26; i++) begin
            if (code == letter_codes[i]) begin
                ch = (shf ^ cap) ? 8'(8'h41 + i) : 8'(8'h61 + i);
                return 1'b1;
            end
        end
        for (int i = 0; i < 10; i++) begin
            if (code == digit_codes[i]) begin
                ch = shf ? 8'(digit_syms[i]) : 8'(8'h30 + i);
                return 1'b1;
            end
        end
        if (code == 8'h29) begin ch = 8'h20; return 1'b1; end
        if (code == 8'h5A) begin ch = 8'h0D; return 1'b1; end
        return 1'b0;
    endfunction

    bit         mv_pop, mv_push;
    logic [7:0] mv_ch;

    always @(posedge clk) begin
        if (!clrn) begin
            m_q.delete();
            m_prefix.delete();
            m_lsh = 0; m_rsh = 0; m_caps = 0; m_caps_down = 0; m_ovf = 0;
            m_cnt = 8'h00;
            m_live = 1'b1;
        end else begin
            mv_pop  = rd_en && (m_q.size() > 0);
            mv_push = 1'b0;
            mv_ch   = 8'h00;
            if (code_valid) begin
                if (m_prefix.size() == 0) begin
                    if (code_in == 8'hF0 || code_in == 8'hE0) begin
                        m_prefix.push_back(code_in);
                    end else begin
                        mv_push = model_char(code_in, m_lsh | m_rsh, m_caps, mv_ch);
                        if (code_in == 8'h12) m_lsh = 1;
                        if (code_in == 8'h59) m_rsh = 1;
                        if (code_in == 8'h58) begin
                            if (!m_caps_down) m_caps = !m_caps;
                            m_caps_down = 1;
                        end
                    end
                end else if (m_prefix[0] == 8'hF0) begin
                    if (code_in == 8'h12) m_lsh = 0;
                    if (code_in == 8'h59) m_rsh = 0;
                    if (code_in == 8'h58) m_caps_down = 0;
                    m_prefix.delete();
                end else if (m_prefix.size() == 1 && code_in == 8'hF0) begin
                    m_prefix.push_back(code_in);   // E0 F0: one more byte to swallow
                end else begin
                    m_prefix.delete();
                end
            end
            if (mv_pop) void'(m_q.pop_front());
            if (mv_push) begin
                m_cnt = m_cnt + 8'd1;
                if (m_q.size() < DEPTH) m_q.push_back(mv_ch);
                else                    m_ovf = 1;
            end
        end
    end

    // Compare process: outputs are register-driven, so the falling edge is a
    // safe sampling point.
    always @(negedge clk) begin
        if (m_live) begin
            check("asc_ready", {31'd0, asc_ready}, {31'd0, m_q.size() > 0});
            check("asc_out",   {24'd0, asc_out},   {24'd0, (m_q.size() > 0) ? m_q[0] : 8'h00});
            check("overflow",  {31'd0, overflow},  {31'd0, m_ovf});
            check("shift_st",  {31'd0, shift_st},  {31'd0, m_lsh | m_rsh});
            check("caps_st",   {31'd0, caps_st},   {31'd0, m_caps});
            check("make_cnt",  {24'd0, make_cnt},  {24'd0, m_cnt});
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers; all called at a falling edge and return at one.
    // -------------------------------------------------------------------------
    task automatic send(input logic [7:0] b);
        code_in = b; code_valid = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
    endtask

    task automatic send_pop(input logic [7:0] b);
        code_in = b; code_valid = 1'b1; rd_en = 1'b1;
        @(negedge clk);
        code_valid = 1'b0; rd_en = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        @(negedge clk);
        clrn = 1'b1;
    endtask

    initial begin
        clrn = 1'b0; code_in = 8'h00; code_valid = 1'b0; rd_en = 1'b0;
        repeat (2) @(negedge clk);
        check("rst asc_ready", {31'd0, asc_ready}, 32'd0);
        check("rst asc_out",   {24'd0, asc_out},   32'h00);
        check("rst make_cnt",  {24'd0, make_cnt},  32'd0);
        check("rst overflow",  {31'd0, overflow},  32'd0);
        clrn = 1'b1;

        // Single make, then pop
        send(8'h1C);
        check("a ready",  {31'd0, asc_ready}, 32'd1);
        check("a char",   {24'd0, asc_out},   32'h61);
        check("a count",  {24'd0, make_cnt},  32'd1);
        pop();
        check("a popped ready", {31'd0, asc_ready}, 32'd0);
        check("a popped out",   {24'd0, asc_out},   32'h00);

        // Shifted letter, then release shift, then plain digit
        send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12); send(8'h16);
        check("shift A", {24'd0, asc_out}, 32'h41);
        pop();
        check("digit 1", {24'd0, asc_out}, 32'h31);
        pop();
        check("shift released", {31'd0, shift_st}, 32'd0);

        // Caps toggle with typematic repeat, caps+shift, shifted digit
        send(8'h58); send(8'h58); send(8'hF0); send(8'h58); send(8'h1C);
        check("caps on", {31'd0, caps_st}, 32'd1);
        check("caps A",  {24'd0, asc_out}, 32'h41);
        pop();
        send(8'h12); send(8'h1C);
        check("caps+shift a", {24'd0, asc_out}, 32'h61);
        pop();
        send(8'h12); send(8'h16);
        check("shift !", {24'd0, asc_out}, 32'h21);
        pop();
        send(8'hF0); send(8'h12);
        send(8'h58); send(8'hF0); send(8'h58);
        check("caps off", {31'd0, caps_st}, 32'd0);

        // Extended sequences produce nothing
        do_reset();
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); send(8'hF0); send(8'h1C);
        check("ext no push", {31'd0, asc_ready}, 32'd0);
        check("ext count",   {24'd0, make_cnt},  32'd0);
        send(8'h1C);
        check("after ext idle", {24'd0, asc_out}, 32'h61);
        pop();

        // Space, Enter, shifted zero, unmapped code
        send(8'h29); send(8'h5A); send(8'h12); send(8'h45); send(8'hF0); send(8'h12); send(8'h07);
        check("space", {24'd0, asc_out}, 32'h20);
        pop();
        check("enter", {24'd0, asc_out}, 32'h0D);
        pop();
        check("paren", {24'd0, asc_out}, 32'h29);
        pop();
        check("unmapped", {31'd0, asc_ready}, 32'd0);

        // Push and pop together on an empty FIFO: push wins
        send_pop(8'h32);
        check("empty push+pop", {24'd0, asc_out}, 32'h62);
        pop();

        // Full FIFO: simultaneous push+pop is not an overflow
        do_reset();
        for (int i = 0; i < DEPTH; i++) send(8'h1C);
        send_pop(8'h1C);
        check("full push+pop ovf", {31'd0, overflow}, 32'd0);

        // Nine makes into a depth-8 FIFO
        do_reset();
        for (int i = 0; i < 9; i++) send(8'h1C);
        check("ovf set",   {31'd0, overflow}, 32'd1);
        check("ovf count", {24'd0, make_cnt}, 32'd9);
        send_pop(8'h1C);
        check("ovf sticky", {31'd0, overflow}, 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            check("drain char", {24'd0, asc_out}, 32'h61);
            pop();
        end
        check("drained", {31'd0, asc_ready}, 32'd0);

        // Reset after a break prefix discards it; inputs ignored during reset
        send(8'hF0);
        clrn = 1'b0; code_in = 8'h1C; code_valid = 1'b1;
        @(negedge clk);
        clrn = 1'b1; code_valid = 1'b0;
        check("rst ignores input", {31'd0, asc_ready}, 32'd0);
        send(8'h1C);
        check("post-rst make", {24'd0, asc_out},  32'h61);
        check("post-rst count", {24'd0, make_cnt}, 32'd1);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/kbd_ascii_fifo.md
KBD_ASCII_FIFO -- requirements
Module: kbd_ascii_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, giving the FIFO depth in characters (power of 2, minimum 2).
REQ-002 SHALL have parameter SHIFT_EN, default 1, enabling shift/caps handling (0: always lowercase, unshifted digits).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port clrn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port code_in  input  8  PS/2 scancode byte from the receiver.
REQ-006 SHALL have port code_valid  input  1  one-cycle strobe marking code_in valid.
REQ-007 SHALL have port rd_en  input  1  pop request for the FIFO head.
REQ-008 SHALL have port asc_out  output  8  ASCII at FIFO head; 0x00 when empty.
REQ-009 SHALL have port asc_ready  output  1  FIFO non-empty.
REQ-010 SHALL have port overflow  output  1  sticky flag: a character was dropped.
REQ-011 SHALL have port shift_st  output  1  either shift key held.
REQ-012 SHALL have port caps_st  output  1  caps-lock latched state.
REQ-013 SHALL have port make_cnt  output  8  count of printable make events, wraps 255->0.

Function
REQ-014 SHALL run a 4-state decoder FSM: IDLE, BRK (after 0xF0), EXT (after 0xE0), EXT_BRK (after 0xE0 0xF0); it advances only on code_valid.
REQ-015 IDLE: 0xF0->BRK; 0xE0->EXT; any other byte -> make handling, stay IDLE.
REQ-016 BRK: any byte -> break handling of that byte, ->IDLE. EXT: 0xF0->EXT_BRK, else ->IDLE with no effect. EXT_BRK: any byte ->IDLE, no effect.
REQ-017 Make 0x12/0x59 SHALL set left/right shift bits; shift_st = OR of both.
REQ-018 Make 0x58 SHALL toggle caps_st only if caps key not already held; typematic 0x58 repeats do not toggle; break 0x58 clears the held flag.
REQ-019 Break 0x12/0x59 SHALL clear the corresponding shift bit; break of any other code has no effect.
REQ-020 Printable makes (letters, digits, 0x29 space->0x20, 0x5A Enter->0x0D) SHALL push one ASCII byte and increment make_cnt; every typematic repeat pushes again.
REQ-021 Letters SHALL be uppercase iff shift_st XOR caps_st; digits with shift_st give US symbols ) ! @ # $ % ^ & * ( for 0..9; caps does not affect digits; shift/caps state used is the value before the current byte.
REQ-022 Unmapped make codes SHALL push nothing and not change make_cnt.
REQ-023 FIFO SHALL be show-ahead: code_valid at cycle n causing a push -> asc_ready=1 and asc_out valid at n+1 (when previously empty).
REQ-024 rd_en with asc_ready=1 SHALL pop the head at the edge; rd_en when empty is ignored.
REQ-025 Push when full without same-cycle pop SHALL drop the new byte, keep contents, set overflow until reset; make_cnt still increments.
REQ-026 Simultaneous push and pop when full SHALL succeed with no overflow; when empty, the push takes effect and the pop is ignored.
REQ-027 Pointers SHALL wrap modulo DEPTH; occupancy counter width log2(DEPTH)+1.

Reset
REQ-028 clrn=0 at a rising edge SHALL set FSM=IDLE, FIFO empty, asc_ready=0, asc_out=0x00, overflow=0, shift_st=0, caps_st=0, caps-held=0, make_cnt=0.
REQ-029 Reset mid-sequence (e.g. after 0xF0) SHALL discard the pending prefix; the next byte is decoded from IDLE.
REQ-030 Inputs SHALL be ignored while clrn=0.

Verification
REQ-031 1C -> asc_ready next cycle, asc_out=0x61, make_cnt=1; rd_en -> asc_ready=0, asc_out=0x00.
REQ-032 12,1C,F0 1C,F0 12,16 -> FIFO 0x41 then 0x31; shift_st=0 at end.
REQ-033 58,58,F0 58,1C -> caps_st=1, 0x41; then 12,1C -> 0x61; then 12,16 with shift held -> 0x21.
REQ-034 E0 75,E0 F0 75,F0 1C -> no push, FSM IDLE, make_cnt=0.
REQ-035 DEPTH=8: nine 1C makes without rd_en -> overflow=1, 8 entries of 0x61, make_cnt=9; push+rd_en when full -> overflow unchanged, count stays 8.
REQ-036 F0 then clrn=0 one cycle, then 1C -> treated as make, asc_out=0x61.
